addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Round-robin arbiter and sequencer that shares one 32-bit ripple adder/subtractor among up to `N_REQ` requesters, such as sensor-averaging, energy-metering and timer units in the smart home controller. It accepts one operation at a time over a valid/ready handshake, registers the operands, and gives the ripple chain a full settle cycle. It then returns a tagged result with a signed-overflow flag to a shared response channel.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag. Derived; not overridden.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `N_REQ`  per-requester operation request.
- `req_ready`  out  `N_REQ`  one-hot grant/accept; handshake completes when valid&ready.
- `req_a`  in  `N_REQ*32`  operand A, requester i at `[32*i+31:32*i]`.
- `req_b`  in  `N_REQ*32`  operand B, same packing.
- `req_sub`  in  `N_REQ`  0 = A+B, 1 = A−B.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  `ID_W`  index of the requester that owns the result.
- `rsp_data`  out  32  result mod 2^32.
- `rsp_ovf`  out  1  two's-complement signed overflow.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate among `req_valid`. If any is set, assert `req_ready[g]` for winner g only. On handshake, capture A, B, sub and g into registers, then go to EXEC. If none is set, stay in IDLE.
  - EXEC: the registered operands drive the adder/subtractor with `sel = sub`. At the end of the cycle, register the sum into `rsp_data` and the overflow into `rsp_ovf`, then go to RESP.
  - RESP: `rsp_valid = 1`, all `rsp_*` held stable. When `rsp_ready = 1`, go to IDLE. Otherwise stay in RESP.
- Arbitration:
  - Round-robin pointer `ptr`, reset 0.
  - Winner is the first set `req_valid` bit scanning `ptr, ptr+1, …, N_REQ−1, 0, …`.
  - On handshake, `ptr` becomes `(g+1) mod N_REQ`. Without a handshake, `ptr` is unchanged.
- `req_ready` is zero outside IDLE. Requests are sampled only in IDLE. A requester may drop `req_valid` before being granted, with no side effect.
- Arithmetic:
  - Subtract is A + ~B + 1, i.e. `sel` drives both the B inversion and the carry-in.
  - Overflow for add: A[31]==B[31] and S[31]!=A[31].
  - Overflow for sub: A[31]!=B[31] and S[31]!=A[31].
  - Carry-out is not reported.
- `rsp_ready` is ignored outside RESP.
- Reset mid-operation: FSM returns to IDLE and all outputs return to reset values. The in-flight result is discarded and not replayed.
- Reset values: `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_data = 0`, `rsp_ovf = 0`, `busy = 0`, `ptr = 0`.

## Timing
- Accept handshake in cycle T: EXEC in T+1, `rsp_valid` high from T+2.
- With `rsp_ready` high, `rsp_valid` lasts one cycle and the next grant can occur at T+3. Peak throughput is therefore one operation per 3 cycles.
- Backpressure: a stalled response blocks all requesters. No queueing.
- `req_ready` is combinational from `req_valid` and `ptr` in IDLE. All `rsp_*` outputs and `busy` are registered.
- The EXEC cycle exists so the 32-stage carry ripple sees stable registered inputs for a full period. No output depends combinationally on the adder.

## Structure
- Package `addsub_pkg`:
  - state enum `{IDLE, EXEC, RESP}`;
  - `DATA_W = 32`;
  - function `signed_ovf(a_msb, b_msb, s_msb, sub)`.
- Single sub-module: the existing `AdderSubtractor32x32`, instantiated once.
- Round-robin pick is an in-module function, not a separate module.

## Test plan
- Single add: requester 2 sends A=5, B=7, add. Expect `req_ready = 4'b0100` for one cycle, then `rsp_valid` 2 cycles later with data=12, id=2, ovf=0.
- Subtract/overflow:
  - 0x00000003 − 0x00000005 → data=0xFFFFFFFE, ovf=0.
  - 0x7FFFFFFF + 1 → data=0x80000000, ovf=1.
  - 0x80000000 − 1 → data=0x7FFFFFFF, ovf=1.
- Fairness: all 4 requesters hold valid continuously with `rsp_ready = 1`. Grants are in order 0,1,2,3,0, each 3 cycles apart.
- Backpressure: hold `rsp_ready = 0` for 10 cycles in RESP. `rsp_*` stay stable, `req_ready` stays 0 and `busy` stays 1. Release: one cycle later the FSM is in IDLE and grants the next requester.
- Reset mid-op: assert `rst_n = 0` during EXEC. All outputs go to 0 asynchronously, no response appears after release, and the next grant goes to requester 0.
- Withdrawn request: requester 1 raises valid while the FSM is in RESP, then drops it before IDLE. Requester 1 is never granted and `ptr` is unaffected.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/sub arbiter.
// State encoding, datapath width, overflow rule.
package addsub_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // Signed overflow: add needs like-signed operands, sub unlike-signed.
  function automatic logic signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb,
    input logic sub
  );
    return ((a_msb ^ b_msb) == sub) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_arbiter_adder.sv
// 32-bit ripple-carry adder/subtractor.
// sel inverts B and supplies the carry-in (A + ~B + 1).
module AdderSubtractor32x32
  import addsub_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] s
);

  // Bit-serial carry ripple from LSB to MSB.
  always_comb begin : ripple
    logic c;
    logic bi;
    s = '0;
    c = sel;
    for (int i = 0; i < DATA_W; i++) begin
      bi   = b[i] ^ sel;
      s[i] = a[i] ^ bi ^ c;
      c    = (a[i] & bi) | (c & (a[i] ^ bi));
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one ripple add/sub unit.
// One op in flight: accept, settle a full cycle, respond.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_ovf,
  output logic                    busy
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                sub_q, sub_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ovf_q, ovf_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic                rv_q, busy_q;
  logic [ID_W-1:0]     grant;
  logic                hs;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   a_sel, b_sel;
  logic                sub_sel;

  // First set bit scanning from p upward with wrap.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [N_REQ-1:0] v,
    input logic [ID_W-1:0]  p
  );
    logic [ID_W-1:0] ix;
    logic [ID_W-1:0] pick;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      ix = ID_W'((int'(p) + k) % N_REQ);
      if (v[ix]) pick = ix;
    end
    return pick;
  endfunction

  AdderSubtractor32x32 u_addsub (
    .a   (a_q),
    .b   (b_q),
    .sel (sub_q),
    .s   (sum)
  );

  // Winner select and operand mux for the granted requester.
  always_comb begin
    grant   = rr_pick(req_valid, ptr_q);
    hs      = (state_q == IDLE) && (|req_valid);
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        a_sel   = req_a[i*DATA_W +: DATA_W];
        b_sel   = req_b[i*DATA_W +: DATA_W];
        sub_sel = req_sub[i];
      end
    end
  end

  // One-hot accept to the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (hs && rst_n) req_ready[grant] = 1'b1;
  end

  // Next-state and datapath register loads.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    id_d    = id_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    rid_d   = rid_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          a_d     = a_sel;
          b_d     = b_sel;
          sub_d   = sub_sel;
          id_d    = grant;
          ptr_d   = ID_W'((int'(grant) + 1) % N_REQ);
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = sum;
        ovf_d   = signed_ovf(a_q[DATA_W-1], b_q[DATA_W-1],
                             sum[DATA_W-1], sub_q);
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      rid_q   <= '0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      id_q    <= id_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      rid_q   <= rid_d;
      rv_q    <= (state_d == RESP);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign rsp_valid = rv_q;
  assign rsp_id    = rid_q;
  assign rsp_data  = data_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter.
// Hand-computed vectors, immediate assertions.
module tb_addsub_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_sub[id]        = s;
  endtask

  // Full transaction from a lone requester with rsp_ready high.
  task automatic do_op(input int id, input logic [31:0] a,
                       input logic [31:0] b, input logic s,
                       input logic [31:0] ed, input logic eo);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    rsp_ready = 1'b1;
    set_op(id, a, b, s);
    req_valid = oh;
    #1;
    chk("grant", {28'b0, req_ready}, {28'b0, oh});
    tick();
    req_valid = '0;
    #1;
    chk("exec_busy", {30'b0, busy, rsp_valid}, 32'h2);
    chk("exec_rdy", {28'b0, req_ready}, 32'h0);
    tick();
    chk("rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_id", {30'b0, rsp_id}, id);
    chk("rsp_ovf", {31'b0, rsp_ovf}, {31'b0, eo});
    tick();
    chk("back_idle", {30'b0, busy, rsp_valid}, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_ready", {28'b0, req_ready}, 32'h0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_id_ovf_busy", {29'b0, rsp_id, rsp_ovf} | {31'b0, busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    do_op(2, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0);
    do_op(3, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0);
    do_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b1);
    do_op(1, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1);

    // Backpressure: ptr=2, req 3 wins, req 0 waits.
    rsp_ready = 1'b0;
    set_op(3, 32'd10, 32'd20, 1'b0);
    set_op(0, 32'd1, 32'd1, 1'b0);
    req_valid = 4'b1001;
    #1;
    chk("bp_grant", {28'b0, req_ready}, 32'h8);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_data", rsp_data, 32'd30);
      chk("bp_id", {30'b0, rsp_id}, 32'd3);
      chk("bp_rdy_busy", {27'b0, req_ready, busy}, 32'h1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_next_grant", {28'b0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    tick();
    chk("bp_next_data", rsp_data, 32'd2);
    chk("bp_next_id", {30'b0, rsp_id}, 32'd0);
    tick();

    // Withdrawn request: ptr=1, req 2 wins.
    set_op(2, 32'd100, 32'd1, 1'b1);
    req_valid = 4'b0100;
    #1;
    chk("wd_grant", {28'b0, req_ready}, 32'h4);
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    chk("wd_data", rsp_data, 32'd99);
    req_valid = 4'b0010;
    tick();
    chk("wd_no_rdy", {28'b0, req_ready}, 32'h0);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk("wd_idle", {28'b0, req_ready, busy}, 32'h0);
    tick();
    chk("wd_still_idle", {31'b0, busy}, 32'h0);
    set_op(1, 32'd4, 32'd4, 1'b0);
    set_op(3, 32'd6, 32'd6, 1'b0);
    req_valid = 4'b1010;
    #1;
    chk("wd_ptr", {28'b0, req_ready}, 32'h8);
    tick();
    req_valid = '0;
    tick();
    chk("wd_ptr_data", rsp_data, 32'd12);
    tick();

    // Reset mid-op: ptr=0, req 2 alone wins.
    set_op(2, 32'd9, 32'd9, 1'b0);
    req_valid = 4'b0100;
    #1;
    chk("mr_grant", {28'b0, req_ready}, 32'h4);
    tick();
    req_valid = '0;
    chk("mr_exec", {31'b0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid0", {31'b0, rsp_valid}, 32'h0);
    chk("mr_data0", rsp_data, 32'h0);
    chk("mr_busy0", {28'b0, req_ready, busy}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_rsp", {31'b0, rsp_valid}, 32'h0);
    end

    // Fairness: all requesters valid, grants 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_op(i, i, 32'd100, 1'b0);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("fair_grant", {28'b0, req_ready}, 32'h1 << (g % 4));
      tick();
      chk("fair_gap1", {28'b0, req_ready}, 32'h0);
      tick();
      chk("fair_rsp_id", {30'b0, rsp_id}, g % 4);
      chk("fair_rsp_data", rsp_data, 32'd100 + (g % 4));
      chk("fair_gap2", {28'b0, req_ready}, 32'h0);
      tick();
    end
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
